// File: rtl/mod_counter_hardcoded.sv
// -----------------------------------------------------------------------------
// mod_counter_hardcoded
//
// Purpose:
//   Modulo-MOD up-counter with an elaboration-time modulus. Counts
//   0, 1, ..., MOD-1 and wraps to 0, advancing only on rising clock edges
//   where enable is high. Intended as a generic divider/sequencer primitive.
//
// Parameters:
//   The modulus parameter sets the wrap point; legal values are 2 .. 2**16,
//   default 10. The width of Q is derived locally as $clog2 of the modulus
//   and cannot be overridden.
//
// Ports:
//   clk      in   1     rising-edge clock
//   reset_n  in   1     asynchronous reset, ACTIVE-HIGH despite the name
//                       (a value of 1 resets; kept for codebase consistency)
//   enable   in   1     count enable, sampled on the rising edge of clk
//   Q        out  BITS  current count, registered
//   tc       out  1     terminal count, combinational (only when the macro
//                       MOD_COUNTER_TC_EN is defined):
//                       tc = enable & (Q == MOD-1), forced low during reset
//
// Optional feature macro: MOD_COUNTER_TC_EN
//   Undefined (default): no tc port, counter otherwise identical.
//   Defined: adds the tc output for cascading counters (tc -> next enable).
// -----------------------------------------------------------------------------
module mod_counter_hardcoded #(
    parameter int MOD = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic [$clog2(MOD)-1:0] Q
`ifdef MOD_COUNTER_TC_EN
    ,
    output logic                   tc
`endif
);

    localparam int BITS = $clog2(MOD);

    // Moduli below 2 give a zero-width counter and are rejected at elaboration.
    if (MOD < 2) begin : g_bad_mod
        $error("mod_counter_hardcoded: MOD must be >= 2 (got %0d)", MOD);
    end

    localparam logic [BITS-1:0] LAST = BITS'(MOD - 1);
    localparam logic [BITS-1:0] ONE  = BITS'(1);

    logic [BITS-1:0] count_q;
    logic [BITS-1:0] count_d;

    // Next-state: a single compare against MOD-1. Using >= rather than ==
    // also pulls any out-of-range value (only reachable by upset, never from
    // reset) back to 0 on the next enabled edge. For power-of-two MOD, LAST
    // is all ones, so this is exactly the natural overflow.
    always_comb begin
        count_d = count_q;
        if (enable) begin
            if (count_q >= LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q = count_q;

`ifdef MOD_COUNTER_TC_EN
    // Reset gating is explicit so tc stays low even if enable is high while
    // reset is held.
    assign tc = enable & ~reset_n & (count_q == LAST);
`endif

endmodule

// File: tb/tb_mod_counter_hardcoded.sv
// -----------------------------------------------------------------------------
// tb_mod_counter_hardcoded
//
// Directed bench for mod_counter_hardcoded. Three instances (MOD = 11, 16, 2)
// share clock, reset and enable. The reference model counts enabled rising
// edges since the last reset; each expected Q is that count modulo MOD.
// A negedge process compares every instance to the model each cycle, and the
// main sequence adds hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_mod_counter_hardcoded;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    logic enable;

    always #5 clk = ~clk;  // rising edges at 5, 15, 25, ... ns

    // ---------------- DUTs ----------------
    logic [3:0] q11;
    logic [3:0] q16;
    logic [0:0] q2;
`ifdef MOD_COUNTER_TC_EN
    logic tc11, tc16, tc2;
`endif

    mod_counter_hardcoded #(.MOD(11)) u_mod11 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .Q(q11)
`ifdef MOD_COUNTER_TC_EN
        , .tc(tc11)
`endif
    );

    mod_counter_hardcoded #(.MOD(16)) u_mod16 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .Q(q16)
`ifdef MOD_COUNTER_TC_EN
        , .tc(tc16)
`endif
    );

    mod_counter_hardcoded #(.MOD(2)) u_mod2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .Q(q2)
`ifdef MOD_COUNTER_TC_EN
        , .tc(tc2)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Number of enabled rising edges since reset was last asserted.
    int n_en = 0;

    always @(posedge clk or posedge reset_n) begin
        if (reset_n === 1'b1) begin
            n_en = 0;
        end else if (enable === 1'b1) begin
            n_en = n_en + 1;
        end
    end

    function automatic logic [31:0] exp_q(input int modv);
        return 32'(n_en % modv);
    endfunction

    function automatic logic [31:0] exp_tc(input int modv);
        return 32'((enable === 1'b1) && (reset_n === 1'b0) && ((n_en % modv) == modv - 1));
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("q11_model", 32'(q11), exp_q(11));
        check("q16_model", 32'(q16), exp_q(16));
        check("q2_model",  32'(q2),  exp_q(2));
`ifdef MOD_COUNTER_TC_EN
        check("tc11_model", 32'(tc11), exp_tc(11));
        check("tc16_model", 32'(tc16), exp_tc(16));
        check("tc2_model",  32'(tc2),  exp_tc(2));
`endif
    end

    // ---------------- driver helpers ----------------
    // Advance k rising edges, then settle 1 ns past the last edge.
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int e11, input int e16, input int e2);
        check({tag, "_q11"}, 32'(q11), 32'(e11));
        check({tag, "_q16"}, 32'(q16), 32'(e16));
        check({tag, "_q2"},  32'(q2),  32'(e2));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_all("reset", 0, 0, 0);            // t=3, still 0 after release
        #1 enable = 1'b1;                           // t=4

        // First edge at 5 ns gives the first increment.
        @(posedge clk); #1;
        check_all("first_inc", 1, 1, 1);

        step(9);                                    // 10 enabled edges
        check_all("e10", 10, 10, 0);
`ifdef MOD_COUNTER_TC_EN
        check("tc11_at_10", 32'(tc11), 32'd1);
        check("tc16_at_10", 32'(tc16), 32'd0);
`endif
        step(1);                                    // 11: MOD=11 wraps
        check_all("e11_wrap", 0, 11, 1);
        step(5);                                    // 16: MOD=16 wraps
        check_all("e16_wrap", 5, 0, 0);

        // Hold at Q11=5 for three edges.
        enable = 1'b0;
        step(3);
        check_all("hold", 5, 0, 0);
        enable = 1'b1;
        step(1);
        check_all("reenable", 6, 1, 1);
        step(1);
        check_all("e18", 7, 2, 0);

        // Asynchronous reset pulse of 3 ns between edges.
        reset_n = 1'b1;                             // edge+1
        #1 check_all("async_rst", 0, 0, 0);         // edge+2, no clock edge yet
        #2 reset_n = 1'b0;                          // edge+4
        step(1);
        check_all("resume", 1, 1, 1);
        step(9);
        check_all("tc_setup", 10, 10, 0);

        // Disable at Q11=10: tc must drop and Q must hold.
        enable = 1'b0;
        #1;
`ifdef MOD_COUNTER_TC_EN
        check("tc11_disabled", 32'(tc11), 32'd0);
`endif
        step(2);
        check_all("hold_at_10", 10, 10, 0);
        enable = 1'b1;
        #1;
`ifdef MOD_COUNTER_TC_EN
        check("tc11_reenabled", 32'(tc11), 32'd1);
`endif
        step(1);
        check_all("wrap_after_hold", 0, 11, 1);

        // Long run over a second MOD=16 wrap (29 enabled edges since reset).
        step(18);
        check_all("long_run", 7, 13, 1);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
